// File: rtl/ddr_pat_pkg.sv
// Shared definitions for the DDR pattern generator/checker.
// pat_lane() is the single definition of the per-lane data pattern.
package ddr_pat_pkg;

  typedef enum logic [1:0] {
    PAT_ADDR_FLAG = 2'd0,
    PAT_ADDR_INV  = 2'd1,
    PAT_WALK1     = 2'd2,
    PAT_CHECKER   = 2'd3
  } pat_mode_e;

  localparam logic [15:0] FLAG_HI     = 16'hAAAA;
  localparam logic [15:0] FLAG_LO     = 16'h5555;
  localparam logic [15:0] LANE_STRIDE = 16'd4;

  // Lane value is seeded by the folded 16-bit address sum, offset per lane.
  function automatic logic [31:0] pat_lane(input logic [31:0] addr,
                                           input logic [4:0]  lane,
                                           input pat_mode_e   mode);
    logic [15:0] b;
    logic [15:0] v;
    logic [15:0] f;
    logic [4:0]  sh;
    logic [31:0] r;
    b  = addr[31:16] + addr[15:0];
    v  = b + LANE_STRIDE * {11'd0, lane};
    f  = v[2] ? FLAG_HI : FLAG_LO;
    sh = b[6:2] + lane;
    r  = '0;
    case (mode)
      PAT_ADDR_FLAG: r = {f, v};
      PAT_ADDR_INV:  r = {~v, v};
      PAT_WALK1:     r = 32'h1 << sh;
      PAT_CHECKER:   r = {f, f};
      default:       r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ddr_pat_lane_gen.sv
// Combinational pattern for every 32-bit lane of one beat.
module ddr_pat_lane_gen
  import ddr_pat_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [31:0]         addr_i,
  input  pat_mode_e           mode_i,
  output logic [32*LANES-1:0] data_o
);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    assign data_o[32*j +: 32] = pat_lane(addr_i, 5'(j), mode_i);
  end

endmodule

// File: rtl/ddr_pattern_gen_chk.sv
// DDR write-pattern generator and two-stage read-back checker with error
// statistics, first-failure capture and a good-beat/idle-timeout indicator.
module ddr_pattern_gen_chk
  import ddr_pat_pkg::*;
#(
  parameter  int DATA_WIDTH      = 256,
  parameter  int RIGHT_CNT_WIDTH = 12,
  parameter  int ERR_CNT_WIDTH   = 16,
  localparam int LANES           = DATA_WIDTH / 32
) (
  input  logic                     SysClk,
  input  logic                     SysRst,
  input  logic [1:0]               PatMode,
  input  logic [31:0]              WrAddrIn,
  input  logic                     WriteEn,
  output logic [DATA_WIDTH-1:0]    DdrWrData,
  input  logic [31:0]              RdAddrIn,
  input  logic                     RdDataEn,
  input  logic [DATA_WIDTH-1:0]    DdrRdData,
  input  logic                     ErrClr,
  output logic                     DdrRdError,
  output logic                     DdrRdRight,
  output logic [ERR_CNT_WIDTH-1:0] ErrCnt,
  output logic [LANES-1:0]         ErrLaneMask,
  output logic                     FirstErrValid,
  output logic [31:0]              FirstErrAddr
);

  localparam logic [ERR_CNT_WIDTH-1:0]   ERR_ONE   = 1;
  localparam logic [RIGHT_CNT_WIDTH-1:0] RIGHT_ONE = 1;

  pat_mode_e             mode;
  logic [DATA_WIDTH-1:0] wrExp, rdExp;

  logic [DATA_WIDTH-1:0]      wrData_q, wrData_d;
  logic [LANES-1:0]           laneErr_q, laneErr_d;
  logic [31:0]                rdAddr1_q;
  logic                       valid1_q;
  logic                       rdErr_q, rdErr_d;
  logic [ERR_CNT_WIDTH-1:0]   errCnt_q, errCnt_d, errBase;
  logic [LANES-1:0]           errMask_q, errMask_d;
  logic                       firstValid_q, firstValid_d;
  logic [31:0]                firstAddr_q, firstAddr_d;
  logic [RIGHT_CNT_WIDTH-1:0] toCnt_q, toCnt_d, rightCnt_q, rightCnt_d;
  logic                       s2Err, timeout;

  assign mode = pat_mode_e'(PatMode);

  // Same generator feeds both sides so the checker can never drift from the writer.
  ddr_pat_lane_gen #(.LANES(LANES)) u_wr_gen (
    .addr_i (WrAddrIn),
    .mode_i (mode),
    .data_o (wrExp)
  );

  ddr_pat_lane_gen #(.LANES(LANES)) u_rd_gen (
    .addr_i (RdAddrIn),
    .mode_i (mode),
    .data_o (rdExp)
  );

  assign s2Err   = valid1_q & (|laneErr_q);
  assign timeout = toCnt_q[RIGHT_CNT_WIDTH-1];

  always_comb begin
    wrData_d = WriteEn ? wrExp : wrData_q;
    laneErr_d = '0;
    for (int j = 0; j < LANES; j++) begin
      laneErr_d[j] = RdDataEn & (DdrRdData[32*j +: 32] != rdExp[32*j +: 32]);
    end
    rdErr_d = s2Err;

    // A clear is applied first so an error resolving in the same cycle survives it.
    errBase      = ErrClr ? '0 : errCnt_q;
    errCnt_d     = errBase;
    errMask_d    = ErrClr ? '0 : errMask_q;
    firstValid_d = ErrClr ? 1'b0 : firstValid_q;
    firstAddr_d  = ErrClr ? '0 : firstAddr_q;
    if (s2Err) begin
      if (errBase != '1) errCnt_d = errBase + ERR_ONE;
      errMask_d = errMask_d | laneErr_q;
      if (!firstValid_d) begin
        firstValid_d = 1'b1;
        firstAddr_d  = rdAddr1_q;
      end
    end

    toCnt_d    = valid1_q ? '0 : ((&toCnt_q) ? toCnt_q : toCnt_q + RIGHT_ONE);
    rightCnt_d = rightCnt_q;
    if (valid1_q) begin
      if (s2Err || timeout)  rightCnt_d = '0;
      else if (!(&rightCnt_q)) rightCnt_d = rightCnt_q + RIGHT_ONE;
    end
  end

  always_ff @(posedge SysClk or posedge SysRst) begin
    if (SysRst) begin
      wrData_q     <= '0;
      laneErr_q    <= '0;
      rdAddr1_q    <= '0;
      valid1_q     <= 1'b0;
      rdErr_q      <= 1'b0;
      errCnt_q     <= '0;
      errMask_q    <= '0;
      firstValid_q <= 1'b0;
      firstAddr_q  <= '0;
      toCnt_q      <= '0;
      rightCnt_q   <= '0;
    end else begin
      wrData_q     <= wrData_d;
      laneErr_q    <= laneErr_d;
      rdAddr1_q    <= RdAddrIn;
      valid1_q     <= RdDataEn;
      rdErr_q      <= rdErr_d;
      errCnt_q     <= errCnt_d;
      errMask_q    <= errMask_d;
      firstValid_q <= firstValid_d;
      firstAddr_q  <= firstAddr_d;
      toCnt_q      <= toCnt_d;
      rightCnt_q   <= rightCnt_d;
    end
  end

  assign DdrWrData     = wrData_q;
  assign DdrRdError    = rdErr_q;
  assign DdrRdRight    = &rightCnt_q;
  assign ErrCnt        = errCnt_q;
  assign ErrLaneMask   = errMask_q;
  assign FirstErrValid = firstValid_q;
  assign FirstErrAddr  = firstAddr_q;

endmodule

// File: tb/tb_ddr_pattern_gen_chk.sv
// Directed self-checking bench for ddr_pattern_gen_chk (256-bit data,
// 12-bit good-beat counter, 4-bit error counter to reach saturation quickly).
module tb_ddr_pattern_gen_chk;

  localparam int DW    = 256;
  localparam int RW    = 12;
  localparam int EW    = 4;
  localparam int LANES = DW / 32;

  logic          SysClk = 1'b0;
  logic          SysRst;
  logic [1:0]    PatMode;
  logic [31:0]   WrAddrIn;
  logic          WriteEn;
  logic [DW-1:0] DdrWrData;
  logic [31:0]   RdAddrIn;
  logic          RdDataEn;
  logic [DW-1:0] DdrRdData;
  logic          ErrClr;
  logic          DdrRdError;
  logic          DdrRdRight;
  logic [EW-1:0] ErrCnt;
  logic [LANES-1:0] ErrLaneMask;
  logic          FirstErrValid;
  logic [31:0]   FirstErrAddr;

  int checks    = 0;
  int errors    = 0;
  int pulseCnt  = 0;
  int pulseBase = 0;

  ddr_pattern_gen_chk #(
    .DATA_WIDTH      (DW),
    .RIGHT_CNT_WIDTH (RW),
    .ERR_CNT_WIDTH   (EW)
  ) dut (
    .SysClk        (SysClk),
    .SysRst        (SysRst),
    .PatMode       (PatMode),
    .WrAddrIn      (WrAddrIn),
    .WriteEn       (WriteEn),
    .DdrWrData     (DdrWrData),
    .RdAddrIn      (RdAddrIn),
    .RdDataEn      (RdDataEn),
    .DdrRdData     (DdrRdData),
    .ErrClr        (ErrClr),
    .DdrRdError    (DdrRdError),
    .DdrRdRight    (DdrRdRight),
    .ErrCnt        (ErrCnt),
    .ErrLaneMask   (ErrLaneMask),
    .FirstErrValid (FirstErrValid),
    .FirstErrAddr  (FirstErrAddr)
  );

  always #5 SysClk = ~SysClk;

  always @(negedge SysClk) begin
    if (DdrRdError === 1'b1) pulseCnt++;
  end

  // Independent reference for the expected beat pattern.
  function automatic logic [DW-1:0] expPattern(input logic [31:0] a, input logic [1:0] m);
    logic [15:0]   b, v, f;
    logic [31:0]   w;
    logic [DW-1:0] r;
    int            s;
    r = '0;
    b = a[31:16] + a[15:0];
    for (int j = 0; j < LANES; j++) begin
      v = b + 16'(4 * j);
      f = v[2] ? 16'hAAAA : 16'h5555;
      s = (int'(b[6:2]) + j) % 32;
      case (m)
        2'd0:    w = {f, v};
        2'd1:    w = {~v, v};
        2'd2:    w = 32'd1 << s;
        default: w = {f, f};
      endcase
      r[32*j +: 32] = w;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic applyStimulus(input logic we, input logic [31:0] wa, input logic re,
                               input logic [31:0] ra, input logic [DW-1:0] rd, input logic clr);
    WriteEn   = we;
    WrAddrIn  = wa;
    RdDataEn  = re;
    RdAddrIn  = ra;
    DdrRdData = rd;
    ErrClr    = clr;
    @(posedge SysClk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  // Write beats are looped back as read beats one cycle later.
  task automatic runLoopback(input int n, input logic [1:0] mode, input logic [31:0] base);
    logic [31:0] addr, prevAddr;
    PatMode  = mode;
    prevAddr = '0;
    for (int i = 0; i < n; i++) begin
      addr = base + 32'(i) * 32'h0000_0024;
      applyStimulus(1'b1, addr, (i > 0), prevAddr, DdrWrData, 1'b0);
      checkOutput("loop_wrdata", DdrWrData, expPattern(addr, mode));
      prevAddr = addr;
    end
    applyStimulus(1'b0, '0, 1'b1, prevAddr, DdrWrData, 1'b0);
    idle(3);
  endtask

  logic [DW-1:0] bad;
  logic [31:0]   lane;

  initial begin
    $display("[TB] start");
    SysRst = 1'b1;
    PatMode = 2'd0; WriteEn = 0; WrAddrIn = 0; RdDataEn = 0; RdAddrIn = 0; DdrRdData = 0; ErrClr = 0;
    repeat (2) @(posedge SysClk);
    #1;
    checkOutput("rst_wrdata", DdrWrData, '0);
    checkOutput("rst_err", DW'(DdrRdError), '0);
    checkOutput("rst_right", DW'(DdrRdRight), '0);
    checkOutput("rst_errcnt", DW'(ErrCnt), '0);
    checkOutput("rst_firstvalid", DW'(FirstErrValid), '0);
    @(negedge SysClk);
    SysRst = 1'b0;

    // Directed write patterns, hand-computed.
    PatMode = 2'd0;
    applyStimulus(1'b1, 32'h0001_0003, 1'b0, '0, '0, 1'b0);
    lane = DdrWrData[31:0];   checkOutput("m0_lane0", DW'(lane), DW'(32'hAAAA_0004));
    lane = DdrWrData[63:32];  checkOutput("m0_lane1", DW'(lane), DW'(32'h5555_0008));
    applyStimulus(1'b0, 32'hFFFF_0002, 1'b0, '0, '0, 1'b0);
    lane = DdrWrData[31:0];   checkOutput("hold_lane0", DW'(lane), DW'(32'hAAAA_0004));
    applyStimulus(1'b1, 32'hFFFF_0002, 1'b0, '0, '0, 1'b0);
    lane = DdrWrData[31:0];   checkOutput("m0_wrap_lane0", DW'(lane), DW'(32'h5555_0001));
    PatMode = 2'd1;
    applyStimulus(1'b1, 32'h0000_0010, 1'b0, '0, '0, 1'b0);
    lane = DdrWrData[31:0];   checkOutput("m1_lane0", DW'(lane), DW'(32'hFFEF_0010));
    lane = DdrWrData[95:64];  checkOutput("m1_lane2", DW'(lane), DW'(32'hFFE7_0018));
    PatMode = 2'd2;
    applyStimulus(1'b1, 32'h0000_007C, 1'b0, '0, '0, 1'b0);
    lane = DdrWrData[31:0];   checkOutput("m2_lane0", DW'(lane), DW'(32'h8000_0000));
    lane = DdrWrData[63:32];  checkOutput("m2_lane1", DW'(lane), DW'(32'h0000_0001));
    PatMode = 2'd3;
    applyStimulus(1'b1, 32'h0000_0000, 1'b0, '0, '0, 1'b0);
    lane = DdrWrData[31:0];   checkOutput("m3_lane0", DW'(lane), DW'(32'h5555_5555));
    lane = DdrWrData[63:32];  checkOutput("m3_lane1", DW'(lane), DW'(32'hAAAA_AAAA));
    idle(2);

    // Loopback: 4094 good beats leave the counter one short of saturation.
    pulseBase = pulseCnt;
    runLoopback(1024, 2'd0, 32'h0000_1000);
    checkOutput("loop_right_early", DW'(DdrRdRight), '0);
    runLoopback(1024, 2'd1, 32'h1234_0000);
    runLoopback(1024, 2'd2, 32'h0000_0004);
    runLoopback(1022, 2'd3, 32'hABCD_0100);
    checkOutput("loop_right_4094", DW'(DdrRdRight), '0);
    runLoopback(1, 2'd0, 32'h0000_0040);
    checkOutput("loop_right_4095", DW'(DdrRdRight), DW'(1'b1));
    checkOutput("loop_no_pulse", DW'(pulseCnt - pulseBase), '0);
    checkOutput("loop_errcnt", DW'(ErrCnt), '0);

    // Single bit flip in lane 1.
    PatMode = 2'd0;
    bad = expPattern(32'h0000_0100, 2'd0) ^ (DW'(1) << 40);
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0100, bad, 1'b0);
    checkOutput("e1_not_yet", DW'(DdrRdError), '0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("e1_pulse", DW'(DdrRdError), DW'(1'b1));
    checkOutput("e1_errcnt", DW'(ErrCnt), DW'(1));
    checkOutput("e1_mask", DW'(ErrLaneMask), DW'(8'h02));
    checkOutput("e1_firstaddr", DW'(FirstErrAddr), DW'(32'h0000_0100));
    checkOutput("e1_firstvalid", DW'(FirstErrValid), DW'(1'b1));
    checkOutput("e1_right_drop", DW'(DdrRdRight), '0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("e1_pulse_end", DW'(DdrRdError), '0);

    // Second error: count advances, first capture untouched.
    bad = expPattern(32'h0000_0200, 2'd0) ^ (DW'(1) << 100);
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0200, bad, 1'b0);
    idle(1);
    checkOutput("e2_errcnt", DW'(ErrCnt), DW'(2));
    checkOutput("e2_mask", DW'(ErrLaneMask), DW'(8'h0A));
    checkOutput("e2_firstaddr", DW'(FirstErrAddr), DW'(32'h0000_0100));

    // Third error resolves on the same cycle as ErrClr: the error wins.
    bad = expPattern(32'h0000_0300, 2'd0) ^ (DW'(1) << 170);
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0300, bad, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("e3_clr_errcnt", DW'(ErrCnt), DW'(1));
    checkOutput("e3_clr_mask", DW'(ErrLaneMask), DW'(8'h20));
    checkOutput("e3_clr_firstaddr", DW'(FirstErrAddr), DW'(32'h0000_0300));
    checkOutput("e3_clr_firstvalid", DW'(FirstErrValid), DW'(1'b1));
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("clr_errcnt", DW'(ErrCnt), '0);
    checkOutput("clr_mask", DW'(ErrLaneMask), '0);
    checkOutput("clr_firstvalid", DW'(FirstErrValid), '0);
    checkOutput("clr_firstaddr", DW'(FirstErrAddr), '0);

    // Twenty back-to-back bad beats saturate the 4-bit counter.
    pulseBase = pulseCnt;
    for (int i = 0; i < 20; i++) begin
      bad = expPattern(32'h0000_4000 + 32'(i * 64), 2'd0) ^ (DW'(1) << (i * 7));
      applyStimulus(1'b0, '0, 1'b1, 32'h0000_4000 + 32'(i * 64), bad, 1'b0);
    end
    idle(3);
    checkOutput("sat_errcnt", DW'(ErrCnt), DW'(4'hF));
    checkOutput("sat_pulses", DW'(pulseCnt - pulseBase), DW'(20));
    checkOutput("sat_firstaddr", DW'(FirstErrAddr), DW'(32'h0000_4000));

    // Refill the good-beat counter, then let the idle timeout expire.
    pulseBase = pulseCnt;
    runLoopback(4095, 2'd3, 32'h0700_0000);
    checkOutput("refill_right", DW'(DdrRdRight), DW'(1'b1));
    checkOutput("refill_errcnt", DW'(ErrCnt), DW'(4'hF));
    checkOutput("refill_no_pulse", DW'(pulseCnt - pulseBase), '0);
    idle(2100);
    checkOutput("idle_right_hold", DW'(DdrRdRight), DW'(1'b1));
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0500, expPattern(32'h0000_0500, 2'd3), 1'b0);
    idle(1);
    checkOutput("timeout_right", DW'(DdrRdRight), '0);
    checkOutput("timeout_no_err", DW'(DdrRdError), '0);

    // Asynchronous reset while a bad beat is in flight.
    idle(1);
    pulseBase = pulseCnt;
    bad = expPattern(32'h0000_0600, 2'd3) ^ (DW'(1) << 3);
    applyStimulus(1'b0, '0, 1'b1, 32'h0000_0600, bad, 1'b0);
    RdDataEn = 1'b0;
    #2 SysRst = 1'b1;
    #1;
    checkOutput("arst_wrdata", DdrWrData, '0);
    checkOutput("arst_err", DW'(DdrRdError), '0);
    checkOutput("arst_right", DW'(DdrRdRight), '0);
    checkOutput("arst_errcnt", DW'(ErrCnt), '0);
    checkOutput("arst_mask", DW'(ErrLaneMask), '0);
    checkOutput("arst_firstvalid", DW'(FirstErrValid), '0);
    checkOutput("arst_firstaddr", DW'(FirstErrAddr), '0);
    @(negedge SysClk);
    SysRst = 1'b0;
    idle(3);
    checkOutput("arst_no_pulse", DW'(pulseCnt - pulseBase), '0);
    checkOutput("arst_errcnt_after", DW'(ErrCnt), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
